tri_raster_scheduler: RTL and testbench
=======================================

TRI_RASTER_SCHEDULER -- requirements
Module: tri_raster_scheduler

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, triangle command queue depth (power of two, 2..16).
REQ-002 SHALL have parameter ID_W, default 8, triangle tag width.
REQ-003 SHALL have parameter CNT_W, default 20, pixel counter width (covers 640*480).
REQ-004 SHALL have parameter BUSY_TIMEOUT, default 4, cycles allowed for rasterizer to drop i_done after o_start.
REQ-005 SHALL have ports:
  i_clk  in  1  clock; one clock, all logic on rising edge.
  i_rst  in  1  reset, synchronous and active-high.
  i_tri_valid  in  1  triangle command offered.
  o_tri_ready  out  1  queue can accept.
  i_tri_v1, i_tri_v2, i_tri_v3  in  64 each  vertices {y,x}, 28.4 fixed point each.
  i_tri_id  in  ID_W  triangle tag.
  o_start  out  1  one-cycle start to rasterizer.
  o_v1, o_v2, o_v3  out  64 each  vertices to rasterizer.
  i_done  in  1  rasterizer done/idle level.
  i_write  in  1  rasterizer pixel strobe.
  i_point  in  32  rasterizer pixel {y[15:0],x[15:0]}.
  o_pix_valid  out  1  forwarded pixel strobe.
  o_pix_point  out  32  forwarded pixel.
  o_pix_id  out  ID_W  tag of triangle owning pixel.
  o_tri_done  out  1  one-cycle completion pulse.
  o_tri_done_id  out  ID_W  tag of completed triangle.
  o_tri_pix_count  out  CNT_W  pixels written by completed triangle.
  o_level  out  $clog2(QUEUE_DEPTH)+1  queue occupancy.
  o_busy  out  1  high unless state IDLE and queue empty.
  o_err  out  1  sticky busy-timeout error.

Function
REQ-006 Queue SHALL push {v1,v2,v3,id} when i_tri_valid && o_tri_ready; o_tri_ready = (o_level < QUEUE_DEPTH), from registered occupancy only.
REQ-007 Push and pop in same cycle SHALL leave o_level unchanged and preserve FIFO order; push when full SHALL be impossible (ready low).
REQ-008 FSM states: DRAIN, IDLE, LAUNCH, WAIT_BUSY, RUN, REPORT.
REQ-009 DRAIN: entered on reset; -> IDLE when i_done==1 (rasterizer has no reset; never start it mid-operation).
REQ-010 IDLE: -> LAUNCH when o_level>0, else stay.
REQ-011 LAUNCH: o_start=1 for exactly this cycle, o_v1..o_v3 = queue head, head popped, id and vertices latched; -> WAIT_BUSY.
REQ-012 o_v1..o_v3 SHALL hold latched values from LAUNCH until next LAUNCH.
REQ-013 WAIT_BUSY: -> RUN when i_done==0; if i_done stays 1 for BUSY_TIMEOUT cycles, set o_err, -> REPORT with count 0.
REQ-014 RUN: -> REPORT on first cycle i_done==1.
REQ-015 Pixel counter SHALL clear in LAUNCH and increment on every i_write in WAIT_BUSY or RUN, including the cycle i_done returns high; saturates at all-ones.
REQ-016 o_pix_valid/o_pix_point/o_pix_id SHALL be registered copies of i_write/i_point/latched id, latency 1, only for i_write in WAIT_BUSY or RUN; i_write in other states ignored.
REQ-017 REPORT: o_tri_done=1 one cycle, o_tri_done_id=latched id, o_tri_pix_count=counter; -> IDLE; done_id/count hold until next REPORT.
REQ-018 Back-to-back triangles: minimum LAUNCH-to-LAUNCH spacing is LAUNCH, WAIT_BUSY, RUN(>=1), REPORT, IDLE.
REQ-019 No backpressure on pixel output; downstream SHALL accept every o_pix_valid.

Reset
REQ-020 i_rst SHALL empty queue (o_level=0, o_tri_ready=1 the cycle after release), state=DRAIN, and zero o_start, o_pix_valid, o_tri_done, o_err, o_pix_point, o_pix_id, o_tri_done_id, o_tri_pix_count, o_v1..o_v3; o_busy=1 in DRAIN.
REQ-021 Reset asserted mid-triangle SHALL drop in-flight triangle without o_tri_done; next start only after DRAIN sees i_done==1.
REQ-022 i_rst SHALL dominate i_tri_valid in the same cycle (no push).

Structure
REQ-023 Shared package SHALL hold FSM state enum, 64-bit vertex type, 32-bit point type, default SCREEN_WIDTH/HEIGHT.
REQ-024 Queue SHALL be sub-module tri_cmd_fifo (synchronous FIFO, width 3*64+ID_W, depth QUEUE_DEPTH); FSM and counters stay in top.

Verification
REQ-025 Reset with model rasterizer i_done=0 for 10 cycles -> no o_start until 1 cycle after i_done=1 and o_level>0.
REQ-026 Push triangle id=0x11 into idle block -> o_start pulses 2 cycles after push; model writes 7 pixels -> 7 o_pix_valid with o_pix_id=0x11, then o_tri_done with count=7.
REQ-027 Push 5 triangles back-to-back with QUEUE_DEPTH=4, rasterizer busy -> o_tri_ready low after 4th accepted, 5th accepted after first LAUNCH; completions in order 0,1,2,3,4.
REQ-028 Model asserts i_write in same cycle i_done rises -> pixel forwarded and counted (count=N+1).
REQ-029 Model never drops i_done after o_start -> after 4 cycles o_err=1, o_tri_done with count=0, next triangle launched.
REQ-030 Assert i_rst during RUN with 2 queued -> o_level=0, no o_tri_done, DRAIN until i_done=1.

Source files
------------

// File: rtl/tri_raster_scheduler_pkg.sv
// Shared types and constants for the triangle raster scheduler.
package tri_raster_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_RUN,
    ST_REPORT
  } state_e;

  // One vertex: {y, x}, each 28.4 fixed point.
  typedef logic [63:0] vertex_t;

  // One rasterized pixel: {y[15:0], x[15:0]}.
  typedef logic [31:0] point_t;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;

endpackage

// File: rtl/tri_raster_scheduler_fifo.sv
// Synchronous command FIFO holding {v1, v2, v3, id} triangle entries.
// The head entry is visible combinationally on o_rdata; occupancy is registered.
module tri_cmd_fifo
  import tri_raster_scheduler_pkg::*;
#(
  parameter int WIDTH = 200,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  // Pointer and occupancy update; callers never push when full or pop when empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(i_push);
    rd_ptr_d = rd_ptr_q + AW'(i_pop);
    level_d  = level_q + LW'(i_push) - LW'(i_pop);
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are meaningless while level is zero, so no reset.
  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wr_ptr_q] <= i_wdata;
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_level = level_q;

endmodule

// File: rtl/tri_raster_scheduler.sv
// Triangle raster scheduler: queues triangle commands, launches them one at a
// time on an external rasterizer, forwards its pixels tagged with the triangle
// id, and reports per-triangle pixel counts with a busy-timeout watchdog.
module tri_raster_scheduler
  import tri_raster_scheduler_pkg::*;
#(
  parameter int QUEUE_DEPTH  = 4,
  parameter int ID_W         = 8,
  parameter int CNT_W        = 20,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_tri_valid,
  output logic                         o_tri_ready,
  input  logic [63:0]                  i_tri_v1,
  input  logic [63:0]                  i_tri_v2,
  input  logic [63:0]                  i_tri_v3,
  input  logic [ID_W-1:0]              i_tri_id,
  output logic                         o_start,
  output logic [63:0]                  o_v1,
  output logic [63:0]                  o_v2,
  output logic [63:0]                  o_v3,
  input  logic                         i_done,
  input  logic                         i_write,
  input  logic [31:0]                  i_point,
  output logic                         o_pix_valid,
  output logic [31:0]                  o_pix_point,
  output logic [ID_W-1:0]              o_pix_id,
  output logic                         o_tri_done,
  output logic [ID_W-1:0]              o_tri_done_id,
  output logic [CNT_W-1:0]             o_tri_pix_count,
  output logic [$clog2(QUEUE_DEPTH):0] o_level,
  output logic                         o_busy,
  output logic                         o_err
);

  localparam int LVL_W  = $clog2(QUEUE_DEPTH) + 1;
  localparam int FIFO_W = 3 * 64 + ID_W;
  localparam int TMO_W  = $clog2(BUSY_TIMEOUT + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic              fifo_push, fifo_pop;
  logic [FIFO_W-1:0] fifo_head;
  logic [LVL_W-1:0]  level;
  vertex_t           head_v1, head_v2, head_v3;
  logic [ID_W-1:0]   head_id;
  logic              pix_ok;
  logic [CNT_W-1:0]  cnt_next;

  state_e            state_q, state_d;
  logic              start_q, start_d;
  vertex_t           v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;
  logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
  logic              pix_valid_q, pix_valid_d;
  point_t            pix_point_q, pix_point_d;
  logic [ID_W-1:0]   pix_id_q, pix_id_d;

  assign o_tri_ready = (level < LVL_W'(QUEUE_DEPTH));
  assign fifo_push   = i_tri_valid && o_tri_ready && !i_rst;
  assign fifo_pop    = (state_q == ST_LAUNCH);

  tri_cmd_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_pop   (fifo_pop),
    .i_wdata ({i_tri_v1, i_tri_v2, i_tri_v3, i_tri_id}),
    .o_rdata (fifo_head),
    .o_level (level)
  );

  assign head_v1 = fifo_head[FIFO_W-1 -: 64];
  assign head_v2 = fifo_head[FIFO_W-65 -: 64];
  assign head_v3 = fifo_head[ID_W+63 -: 64];
  assign head_id = fifo_head[ID_W-1:0];

  // Pixels only belong to a triangle while the rasterizer may be working on it.
  assign pix_ok = i_write && ((state_q == ST_WAIT_BUSY) || (state_q == ST_RUN));

  // Next-state and next-output logic for the launch/report sequencer.
  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    done_d      = 1'b0;
    v1_d        = v1_q;
    v2_d        = v2_q;
    v3_d        = v3_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    done_id_d   = done_id_q;
    done_cnt_d  = done_cnt_q;
    cnt_next    = pix_ok ? sat_inc(cnt_q) : cnt_q;
    pix_valid_d = pix_ok;
    pix_point_d = pix_ok ? i_point : pix_point_q;
    pix_id_d    = pix_ok ? id_q : pix_id_q;
    case (state_q)
      // Rasterizer has no reset: wait until it reports idle before using it.
      ST_DRAIN: if (i_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (level != '0) begin
          state_d = ST_LAUNCH;
          start_d = 1'b1;
          v1_d    = head_v1;
          v2_d    = head_v2;
          v3_d    = head_v3;
          id_d    = head_id;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        tmo_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        cnt_d = cnt_next;
        if (!i_done) begin
          state_d = ST_RUN;
        end else if (tmo_q == TMO_W'(BUSY_TIMEOUT - 1)) begin
          // Rasterizer never acknowledged the start: report an empty triangle.
          err_d      = 1'b1;
          done_d     = 1'b1;
          done_id_d  = id_q;
          done_cnt_d = '0;
          state_d    = ST_REPORT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RUN: begin
        cnt_d = cnt_next;
        if (i_done) begin
          done_d     = 1'b1;
          done_id_d  = id_q;
          done_cnt_d = cnt_next;
          state_d    = ST_REPORT;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_DRAIN;
    endcase
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_DRAIN;
      start_q     <= 1'b0;
      v1_q        <= '0;
      v2_q        <= '0;
      v3_q        <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      done_cnt_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_point_q <= '0;
      pix_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      done_cnt_q  <= done_cnt_d;
      pix_valid_q <= pix_valid_d;
      pix_point_q <= pix_point_d;
      pix_id_q    <= pix_id_d;
    end
  end

  assign o_start         = start_q;
  assign o_v1            = v1_q;
  assign o_v2            = v2_q;
  assign o_v3            = v3_q;
  assign o_pix_valid     = pix_valid_q;
  assign o_pix_point     = pix_point_q;
  assign o_pix_id        = pix_id_q;
  assign o_tri_done      = done_q;
  assign o_tri_done_id   = done_id_q;
  assign o_tri_pix_count = done_cnt_q;
  assign o_level         = level;
  assign o_busy          = !((state_q == ST_IDLE) && (level == '0));
  assign o_err           = err_q;

endmodule

// File: tb/tb_tri_raster_scheduler.sv
// Directed-plus-random bench for tri_raster_scheduler with an in-bench
// rasterizer model and a reference queue of accepted triangles.
module tb_tri_raster_scheduler;

  localparam int QD  = 4;
  localparam int IDW = 8;
  localparam int CW  = 20;
  localparam int BT  = 4;

  typedef logic [191:0] v_t;
  typedef struct packed {
    logic [63:0]    v1;
    logic [63:0]    v2;
    logic [63:0]    v3;
    logic [IDW-1:0] id;
  } tri_t;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_tri_valid;
  logic                 o_tri_ready;
  logic [63:0]          i_tri_v1, i_tri_v2, i_tri_v3;
  logic [IDW-1:0]       i_tri_id;
  logic                 o_start;
  logic [63:0]          o_v1, o_v2, o_v3;
  logic                 i_done;
  logic                 i_write;
  logic [31:0]          i_point;
  logic                 o_pix_valid;
  logic [31:0]          o_pix_point;
  logic [IDW-1:0]       o_pix_id;
  logic                 o_tri_done;
  logic [IDW-1:0]       o_tri_done_id;
  logic [CW-1:0]        o_tri_pix_count;
  logic [$clog2(QD):0]  o_level;
  logic                 o_busy;
  logic                 o_err;

  tri_t exp_q[$];
  tri_t cur_tri;
  int   tests = 0;
  int   fails = 0;

  tri_raster_scheduler #(
    .QUEUE_DEPTH (QD),
    .ID_W        (IDW),
    .CNT_W       (CW),
    .BUSY_TIMEOUT(BT)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_tri_valid     (i_tri_valid),
    .o_tri_ready     (o_tri_ready),
    .i_tri_v1        (i_tri_v1),
    .i_tri_v2        (i_tri_v2),
    .i_tri_v3        (i_tri_v3),
    .i_tri_id        (i_tri_id),
    .o_start         (o_start),
    .o_v1            (o_v1),
    .o_v2            (o_v2),
    .o_v3            (o_v3),
    .i_done          (i_done),
    .i_write         (i_write),
    .i_point         (i_point),
    .o_pix_valid     (o_pix_valid),
    .o_pix_point     (o_pix_point),
    .o_pix_id        (o_pix_id),
    .o_tri_done      (o_tri_done),
    .o_tri_done_id   (o_tri_done_id),
    .o_tri_pix_count (o_tri_pix_count),
    .o_level         (o_level),
    .o_busy          (o_busy),
    .o_err           (o_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input v_t obs, input v_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a new random triangle with the given id.
  task automatic offer(input logic [IDW-1:0] id);
    cur_tri.v1  = {$urandom, $urandom};
    cur_tri.v2  = {$urandom, $urandom};
    cur_tri.v3  = {$urandom, $urandom};
    cur_tri.id  = id;
    i_tri_v1    = cur_tri.v1;
    i_tri_v2    = cur_tri.v2;
    i_tri_v3    = cur_tri.v3;
    i_tri_id    = cur_tri.id;
    i_tri_valid = 1'b1;
  endtask

  // Advance one clock; record the offered triangle in the reference queue if accepted.
  task automatic step();
    bit acc;
    acc = i_tri_valid && o_tri_ready && !i_rst;
    @(posedge i_clk);
    #1;
    if (acc) begin
      exp_q.push_back(cur_tri);
      i_tri_valid = 1'b0;
    end
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!o_start && n < 40) begin
      step();
      n++;
    end
    chk(tag, v_t'(o_start), v_t'(1));
  endtask

  task automatic launch_check(output tri_t t);
    chk("model_nonempty", v_t'(exp_q.size() != 0), v_t'(1));
    if (exp_q.size() != 0) t = exp_q.pop_front();
    else t = '0;
    chk("launch_v1", v_t'(o_v1), v_t'(t.v1));
    chk("launch_v2", v_t'(o_v2), v_t'(t.v2));
    chk("launch_v3", v_t'(o_v3), v_t'(t.v3));
  endtask

  // Rasterizer model: called in the cycle o_start is seen; writes n_pix pixels
  // with random gaps, then raises done (optionally with one more pixel).
  task automatic serve(input int n_pix, input bit wr_on_done);
    tri_t        t;
    int          written;
    bit          w;
    logic [31:0] p;
    launch_check(t);
    i_done = 1'b0;
    step();
    chk("start_one_cycle", v_t'(o_start), v_t'(0));
    written = 0;
    do begin
      w       = (written < n_pix) && ($urandom_range(0, 3) != 0);
      p       = $urandom;
      i_write = w;
      i_point = p;
      step();
      i_write = 1'b0;
      if (w) begin
        written++;
        chk("pix_valid", v_t'(o_pix_valid), v_t'(1));
        chk("pix_point", v_t'(o_pix_point), v_t'(p));
        chk("pix_id", v_t'(o_pix_id), v_t'(t.id));
      end else begin
        chk("pix_quiet", v_t'(o_pix_valid), v_t'(0));
      end
    end while (written < n_pix);
    chk("no_early_done", v_t'(o_tri_done), v_t'(0));
    p       = $urandom;
    i_done  = 1'b1;
    i_write = wr_on_done;
    i_point = p;
    step();
    i_write = 1'b0;
    if (wr_on_done) begin
      chk("pix_on_done_valid", v_t'(o_pix_valid), v_t'(1));
      chk("pix_on_done_point", v_t'(o_pix_point), v_t'(p));
    end
    chk("tri_done", v_t'(o_tri_done), v_t'(1));
    chk("done_id", v_t'(o_tri_done_id), v_t'(t.id));
    chk("done_count", v_t'(o_tri_pix_count), v_t'(n_pix + int'(wr_on_done)));
    chk("v1_hold", v_t'(o_v1), v_t'(t.v1));
    step();
    chk("done_pulse", v_t'(o_tri_done), v_t'(0));
    chk("count_hold", v_t'(o_tri_pix_count), v_t'(n_pix + int'(wr_on_done)));
  endtask

  initial begin
    tri_t t;
    bit   seen;
    int   n;

    // Reset with a triangle offered: reset must win and nothing is queued.
    i_rst   = 1'b1;
    i_done  = 1'b0;
    i_write = 1'b0;
    i_point = '0;
    offer(8'hAA);
    step();
    step();
    chk("rst_level", v_t'(o_level), v_t'(0));
    chk("rst_start", v_t'(o_start), v_t'(0));
    chk("rst_pix_valid", v_t'(o_pix_valid), v_t'(0));
    chk("rst_pix_point", v_t'(o_pix_point), v_t'(0));
    chk("rst_pix_id", v_t'(o_pix_id), v_t'(0));
    chk("rst_tri_done", v_t'(o_tri_done), v_t'(0));
    chk("rst_done_id", v_t'(o_tri_done_id), v_t'(0));
    chk("rst_count", v_t'(o_tri_pix_count), v_t'(0));
    chk("rst_err", v_t'(o_err), v_t'(0));
    chk("rst_v", v_t'({o_v1, o_v2, o_v3}), v_t'(0));
    i_rst       = 1'b0;
    i_tri_valid = 1'b0;
    step();
    chk("post_rst_ready", v_t'(o_tri_ready), v_t'(1));
    chk("post_rst_level", v_t'(o_level), v_t'(0));
    chk("drain_busy", v_t'(o_busy), v_t'(1));

    // Rasterizer still busy after reset: no start until it reports done.
    offer(IDW'($urandom));
    step();
    chk("drain_level", v_t'(o_level), v_t'(1));
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_start) seen = 1'b1;
    end
    chk("drain_no_start", v_t'(seen), v_t'(0));
    i_done = 1'b1;
    step();
    chk("drain_exit_no_start", v_t'(o_start), v_t'(1'b0));
    step();
    chk("drain_exit_start", v_t'(o_start), v_t'(1));
    serve($urandom_range(0, 4), 1'b0);

    // Pixel strobe while idle is ignored.
    i_write = 1'b1;
    i_point = $urandom;
    step();
    i_write = 1'b0;
    chk("idle_write_ignored", v_t'(o_pix_valid), v_t'(0));
    chk("idle_not_busy", v_t'(o_busy), v_t'(0));

    // Single triangle 0x11 with exactly 7 pixels.
    offer(8'h11);
    step();
    chk("t11_no_start_yet", v_t'(o_start), v_t'(0));
    step();
    chk("t11_start", v_t'(o_start), v_t'(1));
    serve(7, 1'b0);

    // Pixel written in the same cycle done rises is forwarded and counted.
    offer(IDW'($urandom));
    step();
    wait_start("start_wod");
    serve($urandom_range(1, 5), 1'b1);

    // Reset during RUN with two triangles still queued.
    i_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      offer(IDW'(8'h40 + k));
      step();
    end
    step();
    chk("run_level", v_t'(o_level), v_t'(2));
    chk("run_v1", v_t'(o_v1), v_t'(exp_q[0].v1));
    i_write = 1'b1;
    i_point = 32'h0012_0034;
    step();
    i_write = 1'b0;
    chk("run_pix_valid", v_t'(o_pix_valid), v_t'(1));
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    exp_q.delete();
    chk("midrst_level", v_t'(o_level), v_t'(0));
    chk("midrst_ready", v_t'(o_tri_ready), v_t'(1));
    chk("midrst_no_done", v_t'(o_tri_done), v_t'(0));
    chk("midrst_busy", v_t'(o_busy), v_t'(1));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_start || o_tri_done) seen = 1'b1;
    end
    chk("midrst_drain_quiet", v_t'(seen), v_t'(0));

    // Five triangles offered back-to-back while the rasterizer is still busy.
    for (int k = 0; k < 4; k++) begin
      offer(IDW'(k));
      step();
    end
    chk("full_level", v_t'(o_level), v_t'(4));
    chk("full_not_ready", v_t'(o_tri_ready), v_t'(0));
    offer(IDW'(4));
    step();
    step();
    chk("full_blocks_5th", v_t'(o_level), v_t'(4));
    i_done = 1'b1;
    wait_start("start_b2b_0");
    serve($urandom_range(0, 5), 1'(($urandom_range(0, 1))));
    for (int k = 1; k < 5; k++) begin
      wait_start("start_b2b");
      serve($urandom_range(0, 5), 1'(($urandom_range(0, 1))));
    end
    chk("b2b_all_served", v_t'(exp_q.size()), v_t'(0));

    // Rasterizer never drops done: timeout error, empty report, next launch.
    offer(8'hE0);
    step();
    offer(8'hE1);
    step();
    wait_start("start_tmo");
    launch_check(t);
    n = 0;
    do begin
      step();
      n++;
    end while (!o_tri_done && n < 20);
    chk("tmo_cycles", v_t'(n), v_t'(BT + 1));
    chk("tmo_err", v_t'(o_err), v_t'(1));
    chk("tmo_count", v_t'(o_tri_pix_count), v_t'(0));
    chk("tmo_id", v_t'(o_tri_done_id), v_t'(t.id));
    step();
    wait_start("start_after_tmo");
    serve($urandom_range(1, 4), 1'b0);
    chk("err_sticky", v_t'(o_err), v_t'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
